// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared types and constants for the capture write-side sequencer.
//   - cap_state_e : acquisition FSM states
//   - EDGE_RISING / EDGE_FALLING : encodings of the edge_i select input
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_e;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_detect.sv
// trigger_detect
//   Level-crossing detector for the armed phase. Holds the previous accepted
//   sample and flags a crossing of level_i by the current sample.
//   Ports:
//     clk_i, rst_i   write-domain clock, async active-low reset
//     clr_i          drop the stored sample (held while the sequencer is idle)
//     load_i         store sample_i as the new previous sample
//     sample_i       current sample
//     level_i        threshold, unsigned
//     edge_i         EDGE_RISING / EDGE_FALLING
//     hit_o          combinational: crossing between stored and current sample
module trigger_detect
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic                  edge_i,
    output logic                  hit_o
);

    logic [DATA_WIDTH-1:0] prev_q;
    logic                  prev_vld_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clr_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (load_i) begin
            prev_q     <= sample_i;
            prev_vld_q <= 1'b1;
        end
    end

    // No crossing can be judged until one sample has been seen in the armed phase.
    always_comb begin
        hit_o = 1'b0;
        if (prev_vld_q) begin
            if (edge_i == EDGE_FALLING)
                hit_o = (prev_q >= level_i) && (sample_i < level_i);
            else
                hit_o = (prev_q < level_i) && (sample_i >= level_i);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl
//   Write-side sequencer for the sample FIFO. Runs pre-trigger, armed and
//   post-trigger acquisition on ADC samples and drives the FIFO write strobe
//   and data one cycle after each accepted sample.
//   Optional feature: define CAPTURE_DECIM_EN to add decim_i[7:0], a prescaler
//   that accepts every (decim_i+1)-th valid sample.
//   Ports:
//     clk_i, rst_i        write clock, async active-low reset
//     start_i, abort_i    acquisition control pulses
//     sample_i/_vld_i     ADC sample stream
//     level_i, edge_i     trigger threshold and direction
//     force_trig_i        force trigger on next accepted sample while armed
//     pre_len_i/post_len_i  lengths, captured at start
//     fifo_full_i         FIFO full flag from the write pointer
//     wr_inc_o, wr_data_o FIFO write strobe and data
//     busy_o, triggered_o, done_o, overflow_o  status (all registered)
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_vld_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic                  edge_i,
    input  logic                  force_trig_i,
    input  logic [CNT_WIDTH-1:0]  pre_len_i,
    input  logic [CNT_WIDTH-1:0]  post_len_i,
    input  logic                  fifo_full_i,
`ifdef CAPTURE_DECIM_EN
    input  logic [7:0]            decim_i,
`endif
    output logic                  wr_inc_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  triggered_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    cap_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_WIDTH-1:0]  pre_len_q, pre_len_d;
    logic [CNT_WIDTH-1:0]  post_len_q, post_len_d;
    logic                  force_pend_q, force_pend_d;
    logic                  trig_q, trig_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_inc_q, wr_inc_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  do_write;
    logic                  accept;
    logic                  hit;

    // ---------------------------------------------------------------
    // Sample acceptance (optional decimation)
    // ---------------------------------------------------------------
`ifdef CAPTURE_DECIM_EN
    logic [7:0] dec_cnt_q;

    assign accept = sample_vld_i && (dec_cnt_q == decim_i);

    // Held at zero while idle so every acquisition starts a fresh phase.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            dec_cnt_q <= '0;
        else if (state_q == IDLE)
            dec_cnt_q <= '0;
        else if (sample_vld_i)
            dec_cnt_q <= accept ? 8'd0 : dec_cnt_q + 8'd1;
    end
`else
    assign accept = sample_vld_i;
`endif

    // ---------------------------------------------------------------
    // Trigger detection
    // ---------------------------------------------------------------
    trigger_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == IDLE),
        .load_i   ((state_q == ARMED) && accept && !abort_i),
        .sample_i (sample_i),
        .level_i  (level_i),
        .edge_i   (edge_i),
        .hit_o    (hit)
    );

    // Counters count samples in time, so they stop at all-ones rather than wrap.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // ---------------------------------------------------------------
    // FSM next state and registered-output next values
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        force_pend_d = force_pend_q;
        trig_d       = trig_q;
        ovf_d        = ovf_q;
        wr_inc_d     = 1'b0;
        wr_data_d    = wr_data_q;
        do_write     = 1'b0;

        if (abort_i && (state_q != IDLE)) begin
            // Abort drops the current sample and never reaches DONE.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        pre_len_d    = pre_len_i;
                        post_len_d   = (post_len_i == '0) ? CNT_WIDTH'(1) : post_len_i;
                        cnt_d        = '0;
                        trig_d       = 1'b0;
                        ovf_d        = 1'b0;
                        force_pend_d = 1'b0;
                        state_d      = (pre_len_i == '0) ? ARMED : PRE;
                    end
                end
                PRE: begin
                    if (accept) begin
                        do_write = 1'b1;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == pre_len_q)
                            state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        if (hit || force_trig_i || force_pend_q) begin
                            do_write     = 1'b1;
                            trig_d       = 1'b1;
                            force_pend_d = 1'b0;
                            cnt_d        = CNT_WIDTH'(1);
                            state_d      = (post_len_q == CNT_WIDTH'(1)) ? DONE : POST;
                        end
                    end else if (force_trig_i) begin
                        // Forced trigger waits for a sample to write.
                        force_pend_d = 1'b1;
                    end
                end
                POST: begin
                    if (accept) begin
                        do_write = 1'b1;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == post_len_q)
                            state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A full FIFO drops the sample but the count already advanced.
            if (do_write) begin
                if (fifo_full_i) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_inc_d  = 1'b1;
                    wr_data_d = sample_i;
                end
            end
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            force_pend_q <= 1'b0;
            trig_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wr_inc_q     <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            force_pend_q <= force_pend_d;
            trig_q       <= trig_d;
            ovf_q        <= ovf_d;
            wr_inc_q     <= wr_inc_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_inc_o    = wr_inc_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign triggered_o = trig_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl
//   Table-driven bench for capture_ctrl: per-cycle vectors of inputs and
//   expected registered outputs, plus hand sequences for async reset and
//   (when CAPTURE_DECIM_EN is defined) decimation.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i, abort_i, sample_vld_i, edge_i, force_trig_i, fifo_full_i;
    logic [7:0]  sample_i, level_i;
    logic [15:0] pre_len_i, post_len_i;
    logic        wr_inc_o, busy_o, triggered_o, done_o, overflow_o;
    logic [7:0]  wr_data_o;
`ifdef CAPTURE_DECIM_EN
    logic [7:0]  decim_i;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    capture_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .level_i      (level_i),
        .edge_i       (edge_i),
        .force_trig_i (force_trig_i),
        .pre_len_i    (pre_len_i),
        .post_len_i   (post_len_i),
        .fifo_full_i  (fifo_full_i),
`ifdef CAPTURE_DECIM_EN
        .decim_i      (decim_i),
`endif
        .wr_inc_o     (wr_inc_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .triggered_o  (triggered_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    // exp flags: {wr_inc, busy, triggered, done, overflow}
    typedef struct {
        logic        st, ab, vld, frc, full;
        logic [7:0]  smp;
        logic [7:0]  level;
        logic        edg;
        logic [15:0] pre, post;
        logic [4:0]  exp;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t        tv[$];
    logic [7:0]  cfg_level;
    logic        cfg_edge;
    logic [15:0] cfg_pre, cfg_post;

    function automatic void add(input logic st, input logic ab, input logic vld,
                                input logic [7:0] smp, input logic frc, input logic full,
                                input logic [4:0] exp, input logic [7:0] exp_data);
        vec_t v;
        v.st = st; v.ab = ab; v.vld = vld; v.smp = smp; v.frc = frc; v.full = full;
        v.level = cfg_level; v.edg = cfg_edge; v.pre = cfg_pre; v.post = cfg_post;
        v.exp = exp; v.exp_data = exp_data;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {wr_inc_o, busy_o, triggered_o, done_o, overflow_o};
    endfunction

    task automatic idle_inputs();
        start_i = 0; abort_i = 0; sample_vld_i = 0; sample_i = 0;
        force_trig_i = 0; fifo_full_i = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        start_i = v.st; abort_i = v.ab; sample_vld_i = v.vld; sample_i = v.smp;
        force_trig_i = v.frc; fifo_full_i = v.full;
        level_i = v.level; edge_i = v.edg; pre_len_i = v.pre; post_len_i = v.post;
        @(posedge clk);
        #1;
        // Data only matters when a write is expected.
        check($sformatf("vec%0d", idx),
              {(v.exp[4] ? wr_data_o : 8'h00), 3'b000, flags()},
              {(v.exp[4] ? v.exp_data : 8'h00), 3'b000, v.exp});
    endtask

    initial begin
        logic [7:0] got_data[$];
        int         nwr;

        // ---- build vector table ----
        // 1: rising, pre=4 post=4, ramp by 0x10
        cfg_level = 8'h80; cfg_edge = 1'b0; cfg_pre = 16'd4; cfg_post = 16'd4;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 8'(i * 16), 0, 0, 5'b11000, 8'(i * 16));
        for (int i = 4; i < 8; i++) add(0, 0, 1, 8'(i * 16), 0, 0, 5'b01000, 8'h00);
        for (int i = 8; i < 11; i++) add(0, 0, 1, 8'(i * 16), 0, 0, 5'b11100, 8'(i * 16));
        add(0, 0, 1, 8'hB0, 0, 0, 5'b11110, 8'hB0);
        add(0, 0, 1, 8'hC0, 0, 0, 5'b00100, 8'h00);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        // 2: falling level 0x40, pre=0 post=2, ramp down from 0xF0
        cfg_level = 8'h40; cfg_edge = 1'b1; cfg_pre = 16'd0; cfg_post = 16'd2;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 0, 1, 8'(8'hF0 - i * 32), 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h30, 0, 0, 5'b11100, 8'h30);
        add(0, 0, 1, 8'h10, 0, 0, 5'b11110, 8'h10);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        // 3a: force with sample on the first armed cycle
        cfg_level = 8'hFF; cfg_edge = 1'b0; cfg_pre = 16'd0; cfg_post = 16'd2;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h11, 1, 0, 5'b11100, 8'h11);
        add(0, 0, 1, 8'h22, 0, 0, 5'b11110, 8'h22);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        // 3b: force without sample waits; post_len 0 acts as 1
        cfg_post = 16'd0;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h05, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 0, 8'h00, 1, 0, 5'b01000, 8'h00);
        add(0, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h06, 0, 0, 5'b11110, 8'h06);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        // 4: FIFO full for 3 samples in POST
        cfg_pre = 16'd1; cfg_post = 16'd5;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h01, 0, 0, 5'b11000, 8'h01);
        add(0, 0, 1, 8'h02, 1, 0, 5'b11100, 8'h02);
        for (int i = 3; i < 6; i++) add(0, 0, 1, 8'(i), 0, 1, 5'b01101, 8'h00);
        add(0, 0, 1, 8'h06, 0, 0, 5'b11111, 8'h06);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00101, 8'h00);
        // 5: abort mid-POST, restart, start+abort in idle
        cfg_pre = 16'd0; cfg_post = 16'd8;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h10, 1, 0, 5'b11100, 8'h10);
        add(0, 0, 1, 8'h20, 0, 0, 5'b11100, 8'h20);
        add(0, 1, 1, 8'h30, 0, 0, 5'b00100, 8'h00);
        add(0, 0, 1, 8'h40, 0, 0, 5'b00100, 8'h00);
        cfg_pre = 16'd1; cfg_post = 16'd1;
        add(1, 0, 0, 8'h00, 0, 0, 5'b01000, 8'h00);
        add(0, 0, 1, 8'h50, 0, 0, 5'b11000, 8'h50);
        add(0, 0, 1, 8'h60, 1, 0, 5'b11110, 8'h60);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        add(1, 1, 0, 8'h00, 0, 0, 5'b00100, 8'h00);
        add(0, 0, 0, 8'h00, 0, 0, 5'b00100, 8'h00);

        // ---- reset ----
        idle_inputs();
        level_i = 0; edge_i = 0; pre_len_i = 0; post_len_i = 0;
`ifdef CAPTURE_DECIM_EN
        decim_i = 8'd0;
`endif
        rst_i = 1'b0;
        #1;
        check("reset_outputs", {wr_data_o, 3'b000, flags()}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;

        // ---- table ----
        for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);

        // ---- async reset in the middle of a run ----
        @(negedge clk);
        idle_inputs();
        start_i = 1; pre_len_i = 16'd2; post_len_i = 16'd2; level_i = 8'hFF; edge_i = 0;
        @(negedge clk);
        start_i = 0; sample_vld_i = 1; sample_i = 8'hAA;
        @(posedge clk);
        #1;
        check("midrun_write", {wr_data_o, 3'b000, flags()}, {8'hAA, 3'b000, 5'b11000});
        #2;
        rst_i = 1'b0;
        #1;
        check("async_reset", {wr_data_o, 3'b000, flags()}, 16'h0000);
        @(negedge clk);
        rst_i = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("post_reset_idle", {wr_data_o, 3'b000, flags()}, 16'h0000);
        @(negedge clk);
        start_i = 1; pre_len_i = 16'd0; post_len_i = 16'd1;
        @(negedge clk);
        start_i = 0; sample_vld_i = 1; sample_i = 8'h77; force_trig_i = 1;
        @(posedge clk);
        #1;
        check("after_reset_run", {wr_data_o, 3'b000, flags()}, {8'h77, 3'b000, 5'b11110});
        @(negedge clk);
        idle_inputs();

`ifdef CAPTURE_DECIM_EN
        // ---- decimation by 4 during PRE ----
        @(negedge clk);
        decim_i = 8'd3; start_i = 1; pre_len_i = 16'd8; post_len_i = 16'd1; level_i = 8'hFF;
        nwr = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start_i = 0; sample_vld_i = 1; sample_i = 8'(i);
            @(posedge clk);
            #1;
            if (wr_inc_o) begin nwr++; got_data.push_back(wr_data_o); end
        end
        @(negedge clk);
        idle_inputs(); abort_i = 1;
        @(posedge clk);
        #1;
        if (wr_inc_o) begin nwr++; got_data.push_back(wr_data_o); end
        check("decim_write_count", 16'(nwr), 16'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("decim_data%0d", k),
                  (k < got_data.size()) ? {8'h00, got_data[k]} : 16'hFFFF,
                  16'(4 * k + 3));
        @(negedge clk);
        idle_inputs();
        decim_i = 8'd0;
`else
        nwr = 0;
        got_data.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
